// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank: op field type and op encodings.
package regbank_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP  = 3'b000;
    localparam op_t OP_LOAD = 3'b001;
    localparam op_t OP_INC  = 3'b010;
    localparam op_t OP_DEC  = 3'b011;
    localparam op_t OP_CLR  = 3'b100;
    localparam op_t OP_SHL  = 3'b101;
    localparam op_t OP_SHR  = 3'b110;

endpackage

// File: rtl/reg_alu_unit.sv
// Combinational next-value / carry computation for one register of the bank.
// 'active' is high for every op that writes the register (not NOP or reserved).
module reg_alu_unit
    import regbank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] nxt,
    output logic             carry,
    output logic             active
);

    always_comb begin
        nxt    = cur;
        carry  = 1'b0;
        active = 1'b1;
        case (op)
            OP_LOAD: nxt = data_in;
            OP_INC:  {carry, nxt} = {1'b0, cur} + (WIDTH+1)'(1);
            OP_DEC: begin
                nxt   = cur - WIDTH'(1);
                carry = (cur == '0);
            end
            OP_CLR:  nxt = '0;
            OP_SHL: begin
                nxt   = {cur[WIDTH-2:0], 1'b0};
                carry = cur[WIDTH-1];
            end
            OP_SHR: begin
                nxt   = {1'b0, cur[WIDTH-1:1]};
                carry = cur[0];
            end
            default: active = 1'b0;
        endcase
    end

endmodule

// File: rtl/register_bank_bus.sv
// DEPTH x WIDTH register bank with one addressed op per cycle and a registered bus-out latch.
// Optional STATUS_FLAGS_EN adds registered zero_flag / carry_flag outputs.
module register_bank_bus
    import regbank_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              main_clock,
    input  logic              reset,
    input  op_t               op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              out_enable,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_valid
`ifdef STATUS_FLAGS_EN
    ,
    output logic              zero_flag,
    output logic              carry_flag
`endif
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             bus_valid_q, bus_valid_d;

    logic [WIDTH-1:0] cur_val, rd_val, alu_nxt;
    logic             alu_carry, alu_active, wr_in_range, do_write;

    // Address decode: out-of-range addresses read as 0 and never match a write slot.
    always_comb begin
        cur_val     = '0;
        rd_val      = '0;
        wr_in_range = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                cur_val     = regs_q[i];
                wr_in_range = 1'b1;
            end
            if (rd_addr == ADDR_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    reg_alu_unit #(.WIDTH(WIDTH)) u_alu (
        .op      (op),
        .cur     (cur_val),
        .data_in (data_in),
        .nxt     (alu_nxt),
        .carry   (alu_carry),
        .active  (alu_active)
    );

    assign do_write = alu_active & wr_in_range;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (do_write && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = alu_nxt;
            end
        end
    end

    // Capture samples the pre-edge register value, so a same-cycle write is not seen.
    always_comb begin
        bus_out_d   = out_enable ? rd_val : bus_out_q;
        bus_valid_d = out_enable;
    end

    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign q         = rd_val;
    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;

`ifdef STATUS_FLAGS_EN
    logic zero_flag_q, zero_flag_d;
    logic carry_flag_q, carry_flag_d;

    always_comb begin
        zero_flag_d  = zero_flag_q;
        carry_flag_d = carry_flag_q;
        if (do_write) begin
            zero_flag_d  = (alu_nxt == '0);
            carry_flag_d = alu_carry;
        end
    end

    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            zero_flag_q  <= zero_flag_d;
            carry_flag_q <= carry_flag_d;
        end
    end

    assign zero_flag  = zero_flag_q;
    assign carry_flag = carry_flag_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

endmodule

// File: tb/tb_register_bank_bus.sv
// Scoreboard bench for register_bank_bus built with DEPTH = 3 so address 3 is out of range.
module tb_register_bank_bus;
    import regbank_pkg::*;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 3;
    localparam int ADDR_W = 2;

    logic              main_clock = 1'b0;
    logic              reset;
    op_t               op;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  data_in;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_enable;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  bus_out;
    logic              bus_valid;
`ifdef STATUS_FLAGS_EN
    logic              zero_flag;
    logic              carry_flag;
`endif

    register_bank_bus #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .main_clock (main_clock),
        .reset      (reset),
        .op         (op),
        .wr_addr    (wr_addr),
        .data_in    (data_in),
        .rd_addr    (rd_addr),
        .out_enable (out_enable),
        .q          (q),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid)
`ifdef STATUS_FLAGS_EN
        ,
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
`endif
    );

    always #5 main_clock = ~main_clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] m_regs [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] last_bus;
    logic             m_zero, m_carry;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_read(input logic [ADDR_W-1:0] a);
        if (int'(a) < DEPTH) return m_regs[a];
        return '0;
    endfunction

    // Reference op behaviour: returns {active, carry, next}.
    function automatic logic [WIDTH+1:0] ref_op(input op_t o, input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] n;
        logic             cy;
        logic             act;
        n = c; cy = 1'b0; act = 1'b1;
        case (o)
            OP_LOAD: n = d;
            OP_INC:  begin n = c + 8'd1; cy = (c == 8'hFF); end
            OP_DEC:  begin n = c - 8'd1; cy = (c == 8'h00); end
            OP_CLR:  n = '0;
            OP_SHL:  begin n = {c[WIDTH-2:0], 1'b0}; cy = c[WIDTH-1]; end
            OP_SHR:  begin n = {1'b0, c[WIDTH-1:1]}; cy = c[0]; end
            default: act = 1'b0;
        endcase
        return {act, cy, n};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        exp_q.delete();
        last_bus = '0;
        m_zero   = 1'b0;
        m_carry  = 1'b0;
    endtask

    task automatic cyc(input op_t o, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] din,
                       input logic [ADDR_W-1:0] ra, input logic oe);
        logic [WIDTH+1:0] r;
        op = o; wr_addr = wa; data_in = din; rd_addr = ra; out_enable = oe;
        if (oe) exp_q.push_back(m_read(ra));
        r = ref_op(o, m_read(wa), din);
        if (r[WIDTH+1] && int'(wa) < DEPTH) begin
            m_regs[wa] = r[WIDTH-1:0];
            m_zero     = (r[WIDTH-1:0] == '0);
            m_carry    = r[WIDTH];
        end
        @(posedge main_clock);
        #1;
        check_eq("bus_valid", bus_valid, oe);
        if (bus_valid) begin
            check_eq("sb_empty", exp_q.size() == 0, 0);
            if (exp_q.size() != 0) last_bus = exp_q.pop_front();
        end
        check_eq("bus_out", bus_out, last_bus);
        check_eq("q", q, m_read(ra));
`ifdef STATUS_FLAGS_EN
        check_eq("zero_flag", zero_flag, m_zero);
        check_eq("carry_flag", carry_flag, m_carry);
`endif
    endtask

    initial begin
        reset = 1'b1;
        op = OP_NOP; wr_addr = '0; data_in = '0; rd_addr = '0; out_enable = 1'b0;
        model_reset();
        #2;
        check_eq("rst_q", q, 0);
        check_eq("rst_bus_out", bus_out, 0);
        check_eq("rst_bus_valid", bus_valid, 0);
        #10 reset = 1'b0;

        // Mid-run asynchronous reset
        cyc(OP_LOAD, 2'd1, 8'h5A, 2'd1, 1'b0);
        cyc(OP_NOP, 2'd0, 8'h00, 2'd1, 1'b1);
        #3 reset = 1'b1;
        #1;
        check_eq("arst_q", q, 0);
        check_eq("arst_bus_out", bus_out, 0);
        check_eq("arst_bus_valid", bus_valid, 0);
        model_reset();
        #2 reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) cyc(OP_NOP, 2'd0, 8'h00, 2'(i), 1'b0);

        // Load and capture, then hold
        cyc(OP_LOAD, 2'd2, 8'h3C, 2'd0, 1'b0);
        cyc(OP_NOP, 2'd0, 8'h00, 2'd2, 1'b1);
        cyc(OP_NOP, 2'd0, 8'h00, 2'd2, 1'b0);
        cyc(OP_NOP, 2'd0, 8'h00, 2'd0, 1'b0);

        // Wrap-around
        cyc(OP_LOAD, 2'd0, 8'hFF, 2'd0, 1'b0);
        cyc(OP_INC, 2'd0, 8'h00, 2'd0, 1'b0);
        cyc(OP_DEC, 2'd0, 8'h00, 2'd0, 1'b0);

        // Same-cycle write/capture hazard, then back-to-back captures
        cyc(OP_LOAD, 2'd2, 8'h10, 2'd2, 1'b0);
        cyc(OP_INC, 2'd2, 8'h00, 2'd2, 1'b1);
        cyc(OP_NOP, 2'd0, 8'h00, 2'd2, 1'b1);
        cyc(OP_NOP, 2'd0, 8'h00, 2'd0, 1'b1);

        // Shifts
        cyc(OP_LOAD, 2'd1, 8'h81, 2'd1, 1'b0);
        cyc(OP_SHL, 2'd1, 8'h00, 2'd1, 1'b0);
        cyc(OP_SHR, 2'd1, 8'h00, 2'd1, 1'b0);
        cyc(OP_SHR, 2'd1, 8'h00, 2'd1, 1'b0);

        // Out-of-range address and reserved op
        cyc(OP_LOAD, 2'd0, 8'h77, 2'd0, 1'b0);
        cyc(OP_LOAD, 2'd3, 8'hAA, 2'd3, 1'b0);
        cyc(OP_INC, 2'd3, 8'h00, 2'd3, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(3'b111, 2'(i), 8'h55, 2'(i), 1'b1);
        cyc(OP_CLR, 2'd0, 8'h00, 2'd0, 1'b1);

        // Random mix
        for (int k = 0; k < 80; k++) begin
            cyc(op_t'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
